pe: RTL and testbench

PE -- requirements
Module: pe

---
 rtl/pe.sv | 36 +++
 tb/tb_pe.sv | 111 +++++++++++
 2 files changed

// File: rtl/pe.sv
// Processing element: unsigned multiply-accumulate into a single register.
// Each non-reset rising edge adds the low DATA_WIDTH bits of a*b to the
// accumulator, wrapping modulo 2^DATA_WIDTH. c is the accumulator register
// itself, so there is no combinational path from a or b to c.
module pe #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] c
);

    logic [DATA_WIDTH-1:0] prod;
    logic [DATA_WIDTH-1:0] acc_d;
    logic [DATA_WIDTH-1:0] acc_q;

    // Next accumulator value. The product is sized to DATA_WIDTH, so its
    // upper half is dropped before the add. The add also wraps at
    // DATA_WIDTH, and the carry-out is discarded.
    always_comb begin
        prod  = a * b;
        acc_d = acc_q + prod;
    end

    // Accumulator register. Reset is synchronous and takes priority, so
    // the product presented on a reset edge is discarded.
    always_ff @(posedge clk) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign c = acc_q;

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe. The driver pushes hand-computed expected c
// values into a queue. The monitor pops one value after each rising edge
// and compares it with c.
module tb_pe;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;
    bit          have_last = 0;

    pe #(.DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Monitor: after each rising edge, compare c with the oldest expected value.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                n_cmp++;
                if (c !== e) begin
                    n_bad++;
                    $display("FAIL edge_check: c=%h expected=%h", c, e);
                end
            end
        end
    end

    // Drive one edge's worth of inputs at the falling edge.
    // Shortly afterwards, confirm that c still holds the previous edge's
    // value. This shows that c is not driven combinationally from a or b,
    // and that rst has no asynchronous effect on c.
    task automatic step(input logic r, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] exp_c);
        @(negedge clk);
        rst = r;
        a   = av;
        b   = bv;
        exp_q.push_back(exp_c);
        #2;
        if (have_last) begin
            n_cmp++;
            if (c !== last_exp) begin
                n_bad++;
                $display("FAIL mid_cycle_stable: c=%h expected=%h", c, last_exp);
            end
        end
        last_exp  = exp_c;
        have_last = 1;
    endtask

    initial begin
        rst = 0;
        a   = 0;
        b   = 0;
        // Reset with nonzero operands presented.
        step(1, 32'd7, 32'd9, 32'h0);
        // Basic accumulation.
        step(0, 32'd1, 32'd1, 32'd1);
        step(0, 32'd2, 32'd2, 32'd5);
        step(0, 32'd3, 32'd3, 32'h0E);
        // A zero operand holds the value, while accumulation still occurs.
        step(0, 32'd0, 32'h12345678, 32'h0E);
        step(0, 32'd0, 32'h12345678, 32'h0E);
        // Wrap of the sum.
        step(1, 32'd0, 32'd0, 32'h0);
        step(0, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
        step(0, 32'd1, 32'd3, 32'h00000001);
        // Product low half is zero.
        step(0, 32'h00010000, 32'h00010000, 32'h00000001);
        // Product truncation.
        step(1, 32'd0, 32'd0, 32'h0);
        step(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        // Reset asserted in the middle of accumulation.
        step(1, 32'd0, 32'd0, 32'h0);
        step(0, 32'd1, 32'd1, 32'd1);
        step(0, 32'd2, 32'd2, 32'd5);
        step(1, 32'd5, 32'd5, 32'h0);
        step(0, 32'd2, 32'd3, 32'd6);
        // Drain the scoreboard within a bounded number of cycles.
        @(negedge clk);
        rst = 0;
        a   = 0;
        b   = 0;
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
